// File: rtl/reaction_pkg.sv
// Shared constants, display-select encodings and value clipping for the reaction statistics block.
package reaction_pkg;

  localparam int unsigned TIME_W     = 10;
  localparam int unsigned MAX_MS     = 999;
  localparam int unsigned RING_DEPTH = 4;
  localparam int unsigned SUM_W      = 12;
  localparam int unsigned TRIALS_W   = 4;

  typedef enum logic [1:0] {
    SEL_LAST   = 2'd0,
    SEL_BEST   = 2'd1,
    SEL_AVG    = 2'd2,
    SEL_TRIALS = 2'd3
  } sel_e;

  // Upstream counter may run past the display range; clamp to the largest showable value.
  function automatic logic [TIME_W-1:0] clip_ms(input logic [TIME_W-1:0] t);
    return (t > TIME_W'(MAX_MS)) ? TIME_W'(MAX_MS) : t;
  endfunction

endpackage

// File: rtl/reaction_stats_if.sv
// Trial input and statistics output bundle for reaction_stats.
interface reaction_stats_if;
  import reaction_pkg::*;

  logic [TIME_W-1:0]   time_ms;
  logic                stop;
  logic                clear_stats;
  logic [1:0]          sel;
  logic [TIME_W-1:0]   disp_value;
  logic                best_valid;
  logic                new_best;
  logic                false_start;
  logic [TRIALS_W-1:0] trials;

  // Timer / user side.
  modport master (
    output time_ms, stop, clear_stats, sel,
    input  disp_value, best_valid, new_best, false_start, trials
  );

  // Statistics block side.
  modport slave (
    input  time_ms, stop, clear_stats, sel,
    output disp_value, best_valid, new_best, false_start, trials
  );

endinterface

// File: rtl/trial_ring.sv
// Ring of the most recent trial times with a fill count and running sum for the average.
module trial_ring
  import reaction_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [TIME_W-1:0] din,
  output logic              full,
  output logic [TIME_W-1:0] avg
);

  localparam int unsigned PtrW  = $clog2(RING_DEPTH);
  localparam int unsigned FillW = $clog2(RING_DEPTH + 1);

  logic [TIME_W-1:0] mem_q [RING_DEPTH];
  logic [PtrW-1:0]   wptr_q;
  logic [FillW-1:0]  fill_q;
  logic [SUM_W-1:0]  sum_q;

  // Write at the pointer, overwriting the oldest entry; the sum swaps out the evicted value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < RING_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= din;
      wptr_q        <= wptr_q + 1'b1;
      if (fill_q != FillW'(RING_DEPTH)) fill_q <= fill_q + 1'b1;
      // Unfilled slots hold zero, so subtracting them is harmless.
      sum_q <= sum_q - SUM_W'(mem_q[wptr_q]) + SUM_W'(din);
    end
  end

  // Average is a truncating divide by the (power-of-two) depth.
  always_comb begin
    full = (fill_q == FillW'(RING_DEPTH));
    avg  = TIME_W'(sum_q >> PtrW);
  end

endmodule

// File: rtl/reaction_stats.sv
// Reaction-time statistics: last, best, 4-trial average and trial count for a 3-digit display.
module reaction_stats
  import reaction_pkg::*;
(
  input logic              CLOCK_50,
  input logic              reset,
  reaction_stats_if.slave  bus
);

  logic                stop_d;
  logic [TIME_W-1:0]   last_q;
  logic [TIME_W-1:0]   best_q;
  logic                best_valid_q;
  logic [TRIALS_W-1:0] trials_q;
  logic                new_best_q;
  logic                false_start_q;

  logic                capture;
  logic [TIME_W-1:0]   value;
  logic                accept;
  logic                reject;
  logic                better;
  logic                ring_full;
  logic [TIME_W-1:0]   ring_avg;

  // Decode the trial-end edge and classify the captured time.
  always_comb begin
    capture = bus.stop & ~stop_d;
    value   = clip_ms(bus.time_ms);
    accept  = capture & (bus.time_ms != '0) & ~bus.clear_stats;
    reject  = capture & (bus.time_ms == '0) & ~bus.clear_stats;
    better  = ~best_valid_q | (value < best_q);
  end

  // Stop history; deliberately untouched by clear_stats so a held stop cannot re-trigger.
  always_ff @(posedge CLOCK_50) begin
    if (reset) stop_d <= 1'b0;
    else       stop_d <= bus.stop;
  end

  // Record updates and one-cycle status pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset || bus.clear_stats) begin
      last_q        <= '0;
      best_q        <= '0;
      best_valid_q  <= 1'b0;
      trials_q      <= '0;
      new_best_q    <= 1'b0;
      false_start_q <= 1'b0;
    end else begin
      new_best_q    <= accept & better;
      false_start_q <= reject;
      if (accept) begin
        last_q       <= value;
        best_valid_q <= 1'b1;
        if (better) best_q <= value;
        if (trials_q != '1) trials_q <= trials_q + 1'b1;
      end
    end
  end

  trial_ring u_ring (
    .clk  (CLOCK_50),
    .rst  (reset),
    .clr  (bus.clear_stats),
    .push (accept),
    .din  (value),
    .full (ring_full),
    .avg  (ring_avg)
  );

  // Display mux; the average falls back to the last time until the ring has filled.
  always_comb begin
    bus.disp_value = last_q;
    unique case (bus.sel)
      SEL_LAST:   bus.disp_value = last_q;
      SEL_BEST:   bus.disp_value = best_q;
      SEL_AVG:    bus.disp_value = ring_full ? ring_avg : last_q;
      SEL_TRIALS: bus.disp_value = TIME_W'(trials_q);
      default:    bus.disp_value = last_q;
    endcase
    bus.best_valid  = best_valid_q;
    bus.new_best    = new_best_q;
    bus.false_start = false_start_q;
    bus.trials      = trials_q;
  end

endmodule

// File: tb/tb_reaction_stats.sv
// Directed bench for reaction_stats with a queue-based reference model checked every cycle.
module tb_reaction_stats;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  bit   run_cmp  = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  reaction_stats_if bus ();

  reaction_stats dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  // Reference model: history of accepted times since the last clear/reset.
  int m_hist[$];
  int m_last, m_best, m_trials;
  bit m_bv, m_nb, m_fs, m_prev_stop;

  function automatic int m_disp(input int s);
    int sum;
    case (s)
      0: return m_last;
      1: return m_best;
      2: begin
        if (m_hist.size() < 4) return m_last;
        sum = 0;
        for (int i = m_hist.size() - 4; i < m_hist.size(); i++) sum += m_hist[i];
        return sum / 4;
      end
      default: return m_trials;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLOCK_50) begin
    int v;
    bit cap;
    m_nb = 1'b0;
    m_fs = 1'b0;
    if (reset) begin
      m_hist.delete();
      m_last = 0; m_best = 0; m_trials = 0; m_bv = 1'b0; m_prev_stop = 1'b0;
    end else begin
      cap = bus.stop && !m_prev_stop;
      m_prev_stop = bus.stop;
      if (bus.clear_stats) begin
        m_hist.delete();
        m_last = 0; m_best = 0; m_trials = 0; m_bv = 1'b0;
      end else if (cap) begin
        v = (int'(bus.time_ms) > 999) ? 999 : int'(bus.time_ms);
        if (v == 0) begin
          m_fs = 1'b1;
        end else begin
          m_last = v;
          if (!m_bv || v < m_best) begin
            m_best = v;
            m_nb   = 1'b1;
          end
          m_bv = 1'b1;
          m_hist.push_back(v);
          if (m_trials < 15) m_trials++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (run_cmp) begin
      check("disp_value", int'(bus.disp_value), m_disp(int'(bus.sel)));
      check("best_valid", int'(bus.best_valid), int'(m_bv));
      check("new_best",   int'(bus.new_best),   int'(m_nb));
      check("false_start", int'(bus.false_start), int'(m_fs));
      check("trials",     int'(bus.trials),     m_trials);
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic lit(input string name, input int s, input int exp);
    bus.sel = 2'(s);
    #1;
    check(name, int'(bus.disp_value), exp);
  endtask

  task automatic trial(input int v, input bit exp_nb, input bit exp_fs);
    bus.time_ms = 10'(v);
    bus.stop    = 1'b1;
    tick();
    check("pulse new_best", int'(bus.new_best), int'(exp_nb));
    check("pulse false_start", int'(bus.false_start), int'(exp_fs));
    bus.stop = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.time_ms     = '0;
    bus.stop        = 1'b0;
    bus.clear_stats = 1'b0;
    bus.sel         = 2'd0;
    reset           = 1'b1;
    tick();
    tick();
    run_cmp = 1'b1;
    lit("rst last", 0, 0); lit("rst best", 1, 0); lit("rst avg", 2, 0); lit("rst trials", 3, 0);
    reset = 1'b0;
    tick();

    // Three trials: pulses on 250 and 180 only.
    trial(250, 1'b1, 1'b0);
    trial(180, 1'b1, 1'b0);
    trial(300, 1'b0, 1'b0);
    lit("t3 last", 0, 300); lit("t3 best", 1, 180); lit("t3 avg fallback", 2, 300);
    lit("t3 trials", 3, 3);
    tick();

    // Ring fills, then evicts the oldest.
    trial(200, 1'b0, 1'b0);
    lit("t4 avg", 2, 232);
    tick();
    trial(100, 1'b1, 1'b0);
    lit("t5 avg", 2, 195); lit("t5 best", 1, 100);
    tick();

    // False start and clipping.
    trial(0, 1'b0, 1'b1);
    lit("fs trials", 3, 5); lit("fs last", 0, 100); lit("fs best", 1, 100);
    tick();
    trial(1020, 1'b0, 1'b0);
    lit("clip last", 0, 999); lit("clip trials", 3, 6);
    tick();

    // Held stop captures once.
    bus.time_ms = 10'd500;
    bus.stop    = 1'b1;
    repeat (50) tick();
    bus.stop = 1'b0;
    tick();
    lit("hold trials", 3, 7); lit("hold last", 0, 500);
    tick();

    // Clear on the capture edge wins; stop held through clear does not capture.
    bus.time_ms     = 10'd50;
    bus.stop        = 1'b1;
    bus.clear_stats = 1'b1;
    tick();
    check("clr new_best", int'(bus.new_best), 0);
    check("clr best_valid", int'(bus.best_valid), 0);
    bus.clear_stats = 1'b0;
    lit("clr last", 0, 0); lit("clr best", 1, 0); lit("clr avg", 2, 0);
    tick();
    repeat (3) tick();
    lit("clr held trials", 3, 0);
    bus.stop = 1'b0;
    tick();

    // Saturation of the trial counter.
    for (int i = 0; i < 17; i++) trial(100 + 7 * i, (i == 0), 1'b0);
    lit("sat trials", 3, 15); lit("sat best", 1, 100); lit("sat last", 0, 212);
    lit("sat avg", 2, 201);
    tick();

    // Reset on a capture edge discards it and zeroes everything.
    bus.time_ms = 10'd40;
    bus.stop    = 1'b1;
    reset       = 1'b1;
    tick();
    check("rst2 best_valid", int'(bus.best_valid), 0);
    lit("rst2 last", 0, 0); lit("rst2 best", 1, 0); lit("rst2 trials", 3, 0);
    reset    = 1'b0;
    bus.stop = 1'b0;
    tick();
    trial(60, 1'b1, 1'b0);
    lit("post trials", 3, 1); lit("post last", 0, 60);
    tick();

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_stats.md
REACTION_STATS -- requirements
Module: reaction_stats

Interface
REQ-001 The block SHALL expose CLOCK_50, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL expose reset, input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL expose time_ms, input, 10 bits, reaction time from the upstream millisecond counter.
REQ-004 The block SHALL expose stop, input, 1 bit, level stop flag from the upstream timer; rising edge = trial end.
REQ-005 The block SHALL expose clear_stats, input, 1 bit, active-high synchronous clear of all records.
REQ-006 The block SHALL expose sel, input, 2 bits, display select: 0 last, 1 best, 2 average, 3 trial count.
REQ-007 The block SHALL expose disp_value, output, 10 bits, selected value, 0..999, for the 3-digit display.
REQ-008 The block SHALL expose best_valid, output, 1 bit, high once at least one valid trial is recorded.
REQ-009 The block SHALL expose new_best, output, 1 bit, one-cycle pulse when a trial sets a new best.
REQ-010 The block SHALL expose false_start, output, 1 bit, one-cycle pulse when a trial is rejected.
REQ-011 The block SHALL expose trials, output, 4 bits, count of valid trials, saturating at 15.

Function
REQ-012 The block SHALL register stop into stop_d each cycle; a capture event is stop=1 and stop_d=0.
REQ-013 A capture with time_ms=0 SHALL be a false start: no record updated, false_start pulses the next cycle.
REQ-014 A capture with time_ms>999 SHALL be clipped to 999 before any use.
REQ-015 A valid capture SHALL, on the capture edge, load last, push the value into the 4-entry ring, and increment trials (saturating at 15).
REQ-016 The block SHALL set best to the captured value and pulse new_best the next cycle when best_valid=0 or value<best; equal values SHALL NOT pulse.
REQ-017 The ring SHALL overwrite its oldest entry when full; the fill count saturates at 4.
REQ-018 average SHALL be (sum of 4 ring entries)>>2 using a 12-bit sum, truncating; with fill<4, sel=2 SHALL show last.
REQ-019 disp_value SHALL be combinational from sel and registered records; sel=3 shows trials zero-extended.
REQ-020 Outputs SHALL reflect a capture one cycle after the capture edge, i.e. one cycle of latency.
REQ-021 A stop held high SHALL produce exactly one capture; a new capture needs stop to go low and then high again.
REQ-022 clear_stats SHALL zero last, best, ring, fill, trials and best_valid, and suppress pulses; it has priority over a simultaneous capture.
REQ-023 clear_stats SHALL NOT clear stop_d, so a stop held high through the clear SHALL NOT capture.

Reset
REQ-024 reset SHALL zero every register including stop_d; all outputs SHALL be 0 in the cycle after reset, with disp_value=0 for every sel.
REQ-025 reset asserted mid-trial or on a capture edge SHALL discard the capture; reset has priority over clear_stats.

Structure
REQ-026 A shared package reaction_pkg SHALL hold MAX_MS=999, RING_DEPTH=4, TIME_W=10 and the sel encodings SEL_LAST/SEL_BEST/SEL_AVG/SEL_TRIALS.
REQ-027 The ring buffer, with write pointer, fill count and running sum, SHALL be one sub-module, trial_ring; the edge detection, best/last logic and output mux stay in reaction_stats.

Verification
REQ-028 reset; trials 250, 180, 300 -> last=300, best=180, trials=3, new_best pulses at 250 and 180 only, sel=2 shows 300.
REQ-029 A fourth trial of 200 (total 930) -> average=232; a fifth trial of 100 evicts 250 -> average=195, best=100.
REQ-030 Capture with time_ms=0 -> false_start pulses once, trials/last/best unchanged; time_ms=1020 -> recorded as 999.
REQ-031 Hold stop high for 50 cycles -> exactly one capture; clear_stats on the capture edge -> all records 0, no pulses.
REQ-032 Apply 17 valid trials -> trials saturates at 15; assert reset mid-sequence -> all outputs 0 on the next cycle.
